// File: rtl/id_stage_reg.sv
// ID/EXE pipeline register with flush-over-freeze priority and a saturating bubble counter.
// Latency 1 cycle; freeze holds every register (no other backpressure), flush inserts a bubble.
module id_stage_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        valid_in,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic        imm_in,
    input  logic [3:0]  exec_cmd_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_r_n_in,
    input  logic [31:0] val_r_m_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  src_1_in,
    input  logic [3:0]  src_2_in,
    input  logic [3:0]  sr_in,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic        mem_w_en_out,
    output logic        b_out,
    output logic        s_out,
    output logic        imm_out,
    output logic [3:0]  exec_cmd_out,
    output logic [31:0] pc_out,
    output logic [31:0] val_r_n_out,
    output logic [31:0] val_r_m_out,
    output logic [11:0] shift_operand_out,
    output logic [23:0] signed_imm_24_out,
    output logic [3:0]  dest_out,
    output logic [3:0]  src_1_out,
    output logic [3:0]  src_2_out,
    output logic [3:0]  sr_out,
    output logic        valid_out,
    output logic [15:0] bubble_count
);

    localparam int ADDRESS_LEN               = 32;
    localparam int REGISTER_FILE_LEN         = 32;
    localparam int REGISTER_FILE_ADDRESS_LEN = 4;
    localparam int EXEC_COMMAND_LEN          = 4;
    localparam int SHIFT_OPERAND_LEN         = 12;
    localparam int SIGNED_IMM_LEN            = 24;

    typedef struct packed {
        logic                                 wb_en;
        logic                                 mem_r_en;
        logic                                 mem_w_en;
        logic                                 b;
        logic                                 s;
        logic                                 imm;
        logic [EXEC_COMMAND_LEN-1:0]          exec_cmd;
        logic [ADDRESS_LEN-1:0]               pc;
        logic [REGISTER_FILE_LEN-1:0]         val_r_n;
        logic [REGISTER_FILE_LEN-1:0]         val_r_m;
        logic [SHIFT_OPERAND_LEN-1:0]         shift_operand;
        logic [SIGNED_IMM_LEN-1:0]            signed_imm_24;
        logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest;
        logic [REGISTER_FILE_ADDRESS_LEN-1:0] src_1;
        logic [REGISTER_FILE_ADDRESS_LEN-1:0] src_2;
        logic [3:0]                           sr;
    } id_bundle_t;

    id_bundle_t  load_dat;
    id_bundle_t  bundle_q;
    logic        valid_q;
    logic [15:0] bubble_q;
    logic        bubble_edge;
    logic [15:0] bubble_next;

    // A hazard bubble keeps its data fields but must never carry side-effecting control.
    always_comb begin
        load_dat               = '0;
        load_dat.wb_en         = wb_en_in    & valid_in;
        load_dat.mem_r_en      = mem_r_en_in & valid_in;
        load_dat.mem_w_en      = mem_w_en_in & valid_in;
        load_dat.b             = b_in        & valid_in;
        load_dat.s             = s_in        & valid_in;
        load_dat.imm           = imm_in;
        load_dat.exec_cmd      = exec_cmd_in;
        load_dat.pc            = pc_in;
        load_dat.val_r_n       = val_r_n_in;
        load_dat.val_r_m       = val_r_m_in;
        load_dat.shift_operand = shift_operand_in;
        load_dat.signed_imm_24 = signed_imm_24_in;
        load_dat.dest          = dest_in;
        load_dat.src_1         = src_1_in;
        load_dat.src_2         = src_2_in;
        load_dat.sr            = sr_in;
    end

    assign bubble_edge = flush | (~freeze & ~valid_in);
    assign bubble_next = (bubble_q == 16'hFFFF) ? bubble_q : bubble_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q <= '0;
            valid_q  <= 1'b0;
            bubble_q <= '0;
        end else begin
            // Flush outranks freeze so a taken branch is never swallowed by a stall.
            if (flush) begin
                bundle_q <= '0;
                valid_q  <= 1'b0;
            end else if (!freeze) begin
                bundle_q <= load_dat;
                valid_q  <= valid_in;
            end
            if (bubble_edge) begin
                bubble_q <= bubble_next;
            end
        end
    end

    assign wb_en_out         = bundle_q.wb_en;
    assign mem_r_en_out      = bundle_q.mem_r_en;
    assign mem_w_en_out      = bundle_q.mem_w_en;
    assign b_out             = bundle_q.b;
    assign s_out             = bundle_q.s;
    assign imm_out           = bundle_q.imm;
    assign exec_cmd_out      = bundle_q.exec_cmd;
    assign pc_out            = bundle_q.pc;
    assign val_r_n_out       = bundle_q.val_r_n;
    assign val_r_m_out       = bundle_q.val_r_m;
    assign shift_operand_out = bundle_q.shift_operand;
    assign signed_imm_24_out = bundle_q.signed_imm_24;
    assign dest_out          = bundle_q.dest;
    assign src_1_out         = bundle_q.src_1;
    assign src_2_out         = bundle_q.src_2;
    assign sr_out            = bundle_q.sr;
    assign valid_out         = valid_q;
    assign bubble_count      = bubble_q;

endmodule

// File: tb/tb_id_stage_reg.sv
// Randomized and directed bench for id_stage_reg against a transaction-level model.
module tb_id_stage_reg;

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic        mw;
        logic        b;
        logic        s;
        logic        imm;
        logic [3:0]  exec;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [11:0] sh;
        logic [23:0] si;
        logic [3:0]  dest;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  sr;
    } bundle_t;

    logic clk;
    logic rst;
    logic freeze;
    logic flush;
    logic valid_in;
    bundle_t din;

    logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
    logic [3:0]  exec_cmd_out, dest_out, src_1_out, src_2_out, sr_out;
    logic [31:0] pc_out, val_r_n_out, val_r_m_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic        valid_out;
    logic [15:0] bubble_count;

    bundle_t dout;
    assign dout = {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out,
                   exec_cmd_out, pc_out, val_r_n_out, val_r_m_out, shift_operand_out,
                   signed_imm_24_out, dest_out, src_1_out, src_2_out, sr_out};

    // Reference model state: what EXE should see, and how many bubbles have entered.
    bundle_t exp_b;
    logic    exp_v;
    int      exp_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    id_stage_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
        .wb_en_in(din.wb), .mem_r_en_in(din.mr), .mem_w_en_in(din.mw),
        .b_in(din.b), .s_in(din.s), .imm_in(din.imm), .exec_cmd_in(din.exec),
        .pc_in(din.pc), .val_r_n_in(din.rn), .val_r_m_in(din.rm),
        .shift_operand_in(din.sh), .signed_imm_24_in(din.si), .dest_in(din.dest),
        .src_1_in(din.s1), .src_2_in(din.s2), .sr_in(din.sr),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .b_out(b_out), .s_out(s_out), .imm_out(imm_out), .exec_cmd_out(exec_cmd_out),
        .pc_out(pc_out), .val_r_n_out(val_r_n_out), .val_r_m_out(val_r_m_out),
        .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .dest_out(dest_out), .src_1_out(src_1_out), .src_2_out(src_2_out), .sr_out(sr_out),
        .valid_out(valid_out), .bubble_count(bubble_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A bubble in EXE must never carry a side-effecting control bit.
    always @(negedge clk) begin
        n_checks++;
        if (!valid_out && (wb_en_out | mem_r_en_out | mem_w_en_out | b_out | s_out)) begin
            n_fail++;
            $display("FAIL bubble_ctrl_invariant: got ctrl=%b%b%b%b%b valid_out=0, required all 0",
                     wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out);
        end
    end

    task automatic rand_din();
        din.wb   = 1'($urandom);
        din.mr   = 1'($urandom);
        din.mw   = 1'($urandom);
        din.b    = 1'($urandom);
        din.s    = 1'($urandom);
        din.imm  = 1'($urandom);
        din.exec = 4'($urandom);
        din.pc   = $urandom;
        din.rn   = $urandom;
        din.rm   = $urandom;
        din.sh   = 12'($urandom);
        din.si   = 24'($urandom);
        din.dest = 4'($urandom);
        din.s1   = 4'($urandom);
        din.s2   = 4'($urandom);
        din.sr   = 4'($urandom);
    endtask

    // Advance one rising edge and update the model with what that edge should do.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            exp_b   = '0;
            exp_v   = 1'b0;
            exp_cnt = 0;
        end else if (flush) begin
            exp_b   = '0;
            exp_v   = 1'b0;
            exp_cnt = (exp_cnt >= 65535) ? 65535 : exp_cnt + 1;
        end else if (!freeze) begin
            exp_b = din;
            exp_v = valid_in;
            if (!valid_in) begin
                exp_b.wb = 1'b0;
                exp_b.mr = 1'b0;
                exp_b.mw = 1'b0;
                exp_b.b  = 1'b0;
                exp_b.s  = 1'b0;
                exp_cnt  = (exp_cnt >= 65535) ? 65535 : exp_cnt + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; valid_in = 1'b1;
        rand_din();
        exp_b = '0; exp_v = 1'b0; exp_cnt = 0;
        #2;
        n_checks++;
        if (dout !== '0 || valid_out !== 1'b0 || bubble_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_initial: got %h v=%b cnt=%h, required all 0", dout, valid_out, bubble_count);
        end
        flush = 1'b1;
        step();
        n_checks++;
        if (dout !== '0 || valid_out !== 1'b0 || bubble_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_held: got %h v=%b cnt=%h, required all 0", dout, valid_out, bubble_count);
        end
        rst = 1'b0; flush = 1'b0; valid_in = 1'b1;
        step();
        n_checks++;
        if (dout !== exp_b || valid_out !== 1'b1 || bubble_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_first_load: got %h v=%b cnt=%h, required %h v=1 cnt=0",
                     dout, valid_out, bubble_count, exp_b);
        end
    endtask

    task automatic test_load();
        int cnt_before;
        cnt_before = exp_cnt;
        din = '0; din.wb = 1'b1; din.exec = 4'b0010; din.pc = 32'h0000_0008; din.dest = 4'd3;
        valid_in = 1'b1; freeze = 1'b0; flush = 1'b0;
        step();
        n_checks++;
        if (wb_en_out !== 1'b1 || exec_cmd_out !== 4'b0010 || pc_out !== 32'h8 || dest_out !== 4'd3
            || valid_out !== 1'b1 || bubble_count !== 16'(cnt_before)) begin
            n_fail++;
            $display("FAIL load_basic: got wb=%b cmd=%h pc=%h dest=%h v=%b cnt=%h, required 1 2 8 3 1 %h",
                     wb_en_out, exec_cmd_out, pc_out, dest_out, valid_out, bubble_count, 16'(cnt_before));
        end
    endtask

    task automatic test_freeze_hold();
        rand_din(); din.rn = 32'hDEAD_BEEF; valid_in = 1'b1;
        step();
        freeze = 1'b1; din.rn = 32'h1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (val_r_n_out !== 32'hDEAD_BEEF || dout !== exp_b || bubble_count !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL freeze_hold[%0d]: got rn=%h cnt=%h, required rn=deadbeef cnt=%h",
                         i, val_r_n_out, bubble_count, 16'(exp_cnt));
            end
        end
        freeze = 1'b0;
        step();
        n_checks++;
        if (val_r_n_out !== 32'h1) begin
            n_fail++;
            $display("FAIL freeze_release: got rn=%h, required 00000001", val_r_n_out);
        end
    endtask

    task automatic test_flush_freeze();
        int cnt_before;
        cnt_before = exp_cnt;
        rand_din(); din.mw = 1'b1; valid_in = 1'b1; freeze = 1'b1; flush = 1'b1;
        step();
        n_checks++;
        if (dout !== '0 || valid_out !== 1'b0 || bubble_count !== 16'(cnt_before + 1)) begin
            n_fail++;
            $display("FAIL flush_over_freeze: got %h v=%b cnt=%h, required 0 v=0 cnt=%h",
                     dout, valid_out, bubble_count, 16'(cnt_before + 1));
        end
        freeze = 1'b0; flush = 1'b0;
    endtask

    task automatic test_hazard_bubble();
        int cnt_before;
        cnt_before = exp_cnt;
        rand_din(); din.wb = 1'b1; din.mr = 1'b1; valid_in = 1'b0;
        step();
        n_checks++;
        if (wb_en_out !== 1'b0 || mem_r_en_out !== 1'b0 || valid_out !== 1'b0
            || bubble_count !== 16'(cnt_before + 1) || pc_out !== din.pc) begin
            n_fail++;
            $display("FAIL hazard_bubble: got wb=%b mr=%b v=%b cnt=%h pc=%h, required 0 0 0 %h %h",
                     wb_en_out, mem_r_en_out, valid_out, bubble_count, pc_out, 16'(cnt_before + 1), din.pc);
        end
        valid_in = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rand_din();
            flush    = ($urandom_range(0, 7) == 0);
            freeze   = ($urandom_range(0, 3) == 0);
            valid_in = ($urandom_range(0, 3) != 0);
            step();
            n_checks++;
            if (dout !== exp_b || valid_out !== exp_v || bubble_count !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h v=%b cnt=%h, required %h v=%b cnt=%h",
                         i, dout, valid_out, bubble_count, exp_b, exp_v, 16'(exp_cnt));
            end
        end
        flush = 1'b0; freeze = 1'b0; valid_in = 1'b1;
    endtask

    task automatic test_async_reset();
        rand_din(); din.pc = 32'h1234_5678; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        n_checks++;
        if (pc_out !== 32'h1234_5678 || bubble_count === 16'h0) begin
            n_fail++;
            $display("FAIL async_pre: got pc=%h cnt=%h, required pc=12345678 cnt nonzero", pc_out, bubble_count);
        end
        freeze = 1'b1; flush = 1'b1;
        #2 rst = 1'b1;
        #1;
        exp_b = '0; exp_v = 1'b0; exp_cnt = 0;
        n_checks++;
        if (dout !== '0 || valid_out !== 1'b0 || bubble_count !== 16'h0) begin
            n_fail++;
            $display("FAIL async_assert: got %h v=%b cnt=%h, required all 0 before edge",
                     dout, valid_out, bubble_count);
        end
        #2 rst = 1'b0;
        freeze = 1'b0; flush = 1'b0; valid_in = 1'b1; rand_din();
        step();
        n_checks++;
        if (dout !== exp_b || valid_out !== 1'b1 || bubble_count !== 16'h0) begin
            n_fail++;
            $display("FAIL async_release_load: got %h v=%b cnt=%h, required %h v=1 cnt=0",
                     dout, valid_out, bubble_count, exp_b);
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        step();
        rst = 1'b0; flush = 1'b1;
        repeat (65534) step();
        n_checks++;
        if (bubble_count !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_preload: got cnt=%h, required fffe", bubble_count);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bubble_count !== 16'hFFFF || bubble_count !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL sat_hold[%0d]: got cnt=%h, required ffff", i, bubble_count);
            end
        end
        flush = 1'b0; valid_in = 1'b0;
        step();
        n_checks++;
        if (bubble_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_no_wrap: got cnt=%h, required ffff", bubble_count);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_freeze_hold();
        test_flush_freeze();
        test_hazard_bubble();
        test_random();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_reg.md
ID_STAGE_REG -- requirements
Module: id_stage_reg

Interface
REQ-001 Parameters: none; all widths are fixed by the shared constants: ADDRESS_LEN=32, REGISTER_FILE_LEN=32, REGISTER_FILE_ADDRESS_LEN=4, EXEC_COMMAND_LEN=4, SHIFT_OPERAND_LEN=12, SIGNED_IMM_LEN=24.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 freeze  in  1  memory stall; hold all register contents.
REQ-005 flush  in  1  taken branch in EXE; replace the captured ID bundle with a bubble.
REQ-006 valid_in  in  1  ID slot holds a real instruction (0 = hazard bubble from ID).
REQ-007 wb_en_in/wb_en_out, mem_r_en_in/mem_r_en_out, mem_w_en_in/mem_w_en_out, b_in/b_out, s_in/s_out, imm_in/imm_out  in/out  1 each  decoded control bits.
REQ-008 exec_cmd_in/exec_cmd_out  in/out  4  ALU command.
REQ-009 pc_in/pc_out  in/out  32  PC+4 of the instruction.
REQ-010 val_r_n_in/val_r_n_out, val_r_m_in/val_r_m_out  in/out  32 each  register-file operands.
REQ-011 shift_operand_in/shift_operand_out  in/out  12  shifter field.
REQ-012 signed_imm_24_in/signed_imm_24_out  in/out  24  branch offset.
REQ-013 dest_in/dest_out, src_1_in/src_1_out, src_2_in/src_2_out  in/out  4 each  register addresses for writeback and forwarding.
REQ-014 sr_in/sr_out  in/out  4  status flags {N,Z,C,V}, sampled with the instruction.
REQ-015 valid_out  out  1  the EXE slot holds a real instruction.
REQ-016 bubble_count  out  16  saturating count of bubbles entering EXE.

Function
REQ-017 Every output shall be driven directly from a flop; there shall be no combinational path from any input to any output.
REQ-018 Each rising edge shall apply exactly one action, in priority order: flush, then freeze, then load.
REQ-019 Load (flush=0, freeze=0): every *_out shall take its *_in value, and valid_out shall take valid_in; latency is 1 cycle.
REQ-020 Load with valid_in=0: wb_en, mem_r_en, mem_w_en, b and s shall be forced to 0, and the data fields shall load as presented.
REQ-021 Freeze (flush=0): all outputs and bubble_count shall hold their values.
REQ-022 Flush: all control bits, exec_cmd, dest, src_1, src_2 and valid_out shall be cleared to 0, and data fields (pc, val_r_n, val_r_m, shift_operand, signed_imm_24, sr, imm) shall also clear to 0.
REQ-023 Flush together with freeze: flush shall win, so a branch is never lost to a stall.
REQ-024 Bubble: an edge that applies flush, or that applies load with valid_in=0, shall increment bubble_count by 1.
REQ-025 bubble_count shall saturate at 16'hFFFF and shall never wrap.
REQ-026 bubble_count shall not change on a freeze edge or on a load edge with valid_in=1.
REQ-027 No control bit of a bubble (valid_out=0) shall ever be 1; verification shall assert this invariant.

Reset
REQ-028 While rst=1, every output shall be 0 immediately, regardless of clk, including valid_out=0 and bubble_count=0.
REQ-029 Reset asserted mid-freeze or mid-flush shall override both.
REQ-030 The first rising edge after rst deasserts shall perform a normal priority-ordered action.

Verification
REQ-031 Load: valid_in=1, wb_en_in=1, exec_cmd_in=4'b0010, pc_in=32'h0000_0008, dest_in=4'd3 -> one edge later, outputs equal the inputs, valid_out=1, bubble_count unchanged.
REQ-032 Freeze hold: load val_r_n_in=32'hDEAD_BEEF, then freeze=1 for 3 edges with inputs changed to 32'h1 -> val_r_n_out stays 32'hDEAD_BEEF; released -> 32'h1 on the next edge.
REQ-033 Flush plus freeze: freeze=1, flush=1, mem_w_en_in=1 -> next edge: all outputs 0, valid_out=0, bubble_count +1.
REQ-034 Hazard bubble: valid_in=0, wb_en_in=1, mem_r_en_in=1 -> next edge: wb_en_out=0, mem_r_en_out=0, valid_out=0, bubble_count +1.
REQ-035 Saturation: preload bubble_count to 16'hFFFE, then 3 flush edges -> 16'hFFFF, 16'hFFFF, 16'hFFFF.
REQ-036 Async reset: assert rst between clock edges while outputs are nonzero -> all outputs are 0 before the next edge; deassert -> the next edge loads normally.
